// File: rtl/gpr_writeback_pkg.sv
// Shared definitions for the GPR write-side front end: load type encodings and byte-lane constants.
package gpr_writeback_pkg;

  typedef enum logic [2:0] {
    LD_LB   = 3'd0,
    LD_LBU  = 3'd1,
    LD_LH   = 3'd2,
    LD_LHU  = 3'd3,
    LD_LW   = 3'd4,
    LD_LWL  = 3'd5,
    LD_LWR  = 3'd6,
    LD_RSVD = 3'd7
  } ld_type_e;

  localparam int         BYTE_LANES  = 4;
  localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

  // Sign- or zero-extend a byte to a full word.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sign_s);
    return {{24{sign_s & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a halfword to a full word.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sign_s);
    return {{16{sign_s & h[15]}}, h};
  endfunction

endpackage

// File: rtl/gpr_writeback_load_align.sv
// Combinational MIPS load alignment: selects and extends bytes/halfwords and builds LWL/LWR merges.
module gpr_writeback_load_align
  import gpr_writeback_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic [3:0]  byte_en,
  output logic        illegal
);

  ld_type_e    type_s;
  logic [31:0] shifted_s;
  logic [15:0] half_s;

  assign type_s = ld_type_e'(ld_type);

  // Alignment mux: lane k is brought to the bottom by shifting right 8*k bits.
  always_comb begin
    shifted_s = word >> {offset, 3'b000};
    half_s    = offset[1] ? word[31:16] : word[15:0];
    data      = word;
    byte_en   = BYTE_EN_ALL;
    illegal   = 1'b0;
    case (type_s)
      LD_LB:  data = ext_byte(shifted_s[7:0], 1'b1);
      LD_LBU: data = ext_byte(shifted_s[7:0], 1'b0);
      LD_LH:  data = ext_half(half_s, 1'b1);
      LD_LHU: data = ext_half(half_s, 1'b0);
      LD_LW:  data = word;
      // 3-k equals ~k for a two-bit offset.
      LD_LWL: begin
        data    = word << {~offset, 3'b000};
        byte_en = BYTE_EN_ALL << ~offset;
      end
      LD_LWR: begin
        data    = shifted_s;
        byte_en = BYTE_EN_ALL >> offset;
      end
      default: begin
        data    = 32'h0000_0000;
        byte_en = 4'b0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/gpr_writeback.sv
// GPR write port front end: merges ALU results and aligned load data into one registered write,
// tracks outstanding loads and flags read-after-write hazards for decode.
module gpr_writeback
  import gpr_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int LOAD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  input  logic [ADDR_WIDTH-1:0] ld_rd,
  input  logic [2:0]            ld_type,
  input  logic [1:0]            ld_offset,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic                  hazard,
  output logic                  rsp_err,
  output logic                  gpr_write,
  output logic [ADDR_WIDTH-1:0] gpr_rd_addr,
  output logic [DATA_WIDTH-1:0] gpr_rd_in,
  output logic [3:0]            gpr_byte_en
);

  localparam int PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  localparam int CNT_W = $clog2(LOAD_DEPTH + 1);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(LOAD_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(LOAD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RD_ZERO  = '0;

  logic [ADDR_WIDTH-1:0] q_rd_r   [LOAD_DEPTH];
  logic [2:0]            q_type_r [LOAD_DEPTH];
  logic [1:0]            q_off_r  [LOAD_DEPTH];
  logic [LOAD_DEPTH-1:0] q_valid_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  not_empty_s;
  logic                  enq_s;
  logic                  deq_s;
  logic                  orphan_s;
  logic [ADDR_WIDTH-1:0] head_rd_s;
  logic [31:0]           align_data_s;
  logic [3:0]            align_be_s;
  logic                  align_illegal_s;
  logic                  rs_hit_s;
  logic                  rt_hit_s;
  logic                  wr_next_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;
  logic [DATA_WIDTH-1:0] data_next_s;
  logic [3:0]            be_next_s;
  logic                  err_set_s;

  // Explicit wrap so non-power-of-two pointer ranges (depth 1) stay in bounds.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty_s  = (count_r != '0);
  assign ld_req_ready = (count_r != CNT_FULL);
  assign enq_s        = ld_req_valid && ld_req_ready;
  assign deq_s        = mem_rsp_valid && not_empty_s;
  assign orphan_s     = mem_rsp_valid && !not_empty_s;
  assign alu_ready    = !deq_s;
  assign head_rd_s    = q_rd_r[rd_ptr_r];

  gpr_writeback_load_align u_align (
    .ld_type (q_type_r[rd_ptr_r]),
    .offset  (q_off_r[rd_ptr_r]),
    .word    (mem_rsp_data),
    .data    (align_data_s),
    .byte_en (align_be_s),
    .illegal (align_illegal_s)
  );

  // Outstanding-load FIFO: entries, valid flags, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      q_valid_r <= '0;
      for (int i = 0; i < LOAD_DEPTH; i++) begin
        q_rd_r[i]   <= '0;
        q_type_r[i] <= 3'd0;
        q_off_r[i]  <= 2'd0;
      end
    end else begin
      if (deq_s) begin
        q_valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r            <= ptr_next(rd_ptr_r);
      end
      if (enq_s) begin
        q_rd_r[wr_ptr_r]    <= ld_rd;
        q_type_r[wr_ptr_r]  <= ld_type;
        q_off_r[wr_ptr_r]   <= ld_offset;
        q_valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r            <= ptr_next(wr_ptr_r);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Hazard: a dequeuing entry is still valid here, and the output stage covers the pre-capture half cycle.
  always_comb begin
    rs_hit_s = gpr_write && (gpr_rd_addr == rs_addr);
    rt_hit_s = gpr_write && (gpr_rd_addr == rt_addr);
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      if (q_valid_r[i]) begin
        rs_hit_s = rs_hit_s || (q_rd_r[i] == rs_addr);
        rt_hit_s = rt_hit_s || (q_rd_r[i] == rt_addr);
      end else begin
        rs_hit_s = rs_hit_s;
        rt_hit_s = rt_hit_s;
      end
    end
    hazard = ((rs_addr != RD_ZERO) && rs_hit_s) || ((rt_addr != RD_ZERO) && rt_hit_s);
  end

  // Write source selection: load responses win; r0 and illegal loads never write.
  always_comb begin
    wr_next_s   = 1'b0;
    addr_next_s = gpr_rd_addr;
    data_next_s = gpr_rd_in;
    be_next_s   = gpr_byte_en;
    err_set_s   = orphan_s;
    if (deq_s) begin
      if (align_illegal_s) begin
        err_set_s = 1'b1;
      end else if (head_rd_s != RD_ZERO) begin
        wr_next_s   = 1'b1;
        addr_next_s = head_rd_s;
        data_next_s = align_data_s;
        be_next_s   = align_be_s;
      end else begin
        wr_next_s = 1'b0;
      end
    end else if (alu_valid && (alu_rd != RD_ZERO)) begin
      wr_next_s   = 1'b1;
      addr_next_s = alu_rd;
      data_next_s = alu_data;
      be_next_s   = BYTE_EN_ALL;
    end else begin
      wr_next_s = 1'b0;
    end
  end

  // Output register, updated on posedge so the GPR's negedge capture sees stable values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr_write   <= 1'b0;
      gpr_rd_addr <= '0;
      gpr_rd_in   <= '0;
      gpr_byte_en <= 4'b0000;
      rsp_err     <= 1'b0;
    end else begin
      gpr_write   <= wr_next_s;
      gpr_rd_addr <= addr_next_s;
      gpr_rd_in   <= data_next_s;
      gpr_byte_en <= be_next_s;
      rsp_err     <= rsp_err || err_set_s;
    end
  end

endmodule
